// File: rtl/riscv_id.sv
// RV32I decode stage: owns the integer register file, decodes OP/OP-IMM into the
// registered operand bundle for EX, and interlocks against the instruction held in EX.
module riscv_id #(
  parameter int XLEN = 32,
  parameter int REGA = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [REGA-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [REGA-1:0] rd,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [5:0]      shamt,
  output logic [2:0]      funct3,
  output logic            invertb,
  output logic            illegal
);

  // Handshake: instr is consumed at a rising edge where instr_valid && instr_ready;
  // instr_ready depends only on the current instr and the registered rd, and the
  // upstream stage must hold instr stable while valid is high and ready is low.

  localparam int NREG = 1 << REGA;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [XLEN-1:0] regs [NREG];

  logic [REGA-1:0] rs1, rs2, dec_rd;
  logic [6:0]      opcode;
  logic [2:0]      dec_f3;
  logic [XLEN-1:0] rs1_val, rs2_val, imm;
  logic            is_op, is_opimm, is_shift, hazard, accept;

  logic [REGA-1:0] rd_n;
  logic [XLEN-1:0] a_n, b_n;
  logic [5:0]      shamt_n;
  logic [2:0]      funct3_n;
  logic            invertb_n, illegal_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign opcode   = instr[6:0];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign dec_rd   = instr[11:7];
  assign dec_f3   = instr[14:12];
  assign imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign is_op    = (opcode == OPC_OP);
  assign is_opimm = (opcode == OPC_OP_IMM);
  assign is_shift = (dec_f3 == 3'b001) || (dec_f3 == 3'b101);

  // Write-first bypass: a same-cycle write-back wins over the array contents.
  assign rs1_val = (rs1 == '0) ? '0 : (rs1 == wb_rd) ? wb_data : regs[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : (rs2 == wb_rd) ? wb_data : regs[rs2];

  assign hazard = instr_valid && (rd != '0) &&
                  (((is_op || is_opimm) && (rs1 == rd)) || (is_op && (rs2 == rd)));
  assign instr_ready = !hazard;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    rd_n      = '0;
    a_n       = '0;
    b_n       = '0;
    shamt_n   = '0;
    funct3_n  = '0;
    invertb_n = 1'b0;
    illegal_n = 1'b0;
    if (accept) begin
      if (is_opimm) begin
        rd_n      = dec_rd;
        a_n       = rs1_val;
        b_n       = imm;
        funct3_n  = dec_f3;
        shamt_n   = is_shift ? {1'b0, instr[24:20]} : 6'd0;
        invertb_n = (dec_f3 == 3'b101) && instr[30];
      end else if (is_op) begin
        rd_n      = dec_rd;
        a_n       = rs1_val;
        funct3_n  = dec_f3;
        shamt_n   = is_shift ? {1'b0, rs2_val[4:0]} : 6'd0;
        invertb_n = ((dec_f3 == 3'b000) || (dec_f3 == 3'b101)) && instr[30];
        // SUB is presented to EX as an ADD of the two's complement of rs2.
        if ((dec_f3 == 3'b000) && instr[30])
          b_n = (~rs2_val) + {{(XLEN-1){1'b0}}, 1'b1};
        else
          b_n = rs2_val;
      end else begin
        illegal_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd      <= '0;
      a       <= '0;
      b       <= '0;
      shamt   <= '0;
      funct3  <= '0;
      invertb <= 1'b0;
      illegal <= 1'b0;
    end else begin
      rd      <= rd_n;
      a       <= a_n;
      b       <= b_n;
      shamt   <= shamt_n;
      funct3  <= funct3_n;
      invertb <= invertb_n;
      illegal <= illegal_n;
    end
  end

endmodule

// File: tb/tb_riscv_id.sv
// Directed bench for riscv_id: table of single-instruction vectors plus hand-written
// sequences for the load-use stall and reset during a stall.
module tb_riscv_id;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rd;
  logic [31:0] a, b;
  logic [5:0]  shamt;
  logic [2:0]  funct3;
  logic        invertb, illegal;

  int checks   = 0;
  int failures = 0;

  riscv_id #(.XLEN(32), .REGA(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .wb_rd(wb_rd), .wb_data(wb_data), .rd(rd),
    .a(a), .b(b), .shamt(shamt), .funct3(funct3), .invertb(invertb),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  shamt;
    logic [2:0]  f3;
    logic        inv;
    logic        ill;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".rd"}, 32'(rd), 32'd0);
    chk({tag, ".a"}, a, 32'd0);
    chk({tag, ".b"}, b, 32'd0);
    chk({tag, ".shamt"}, 32'(shamt), 32'd0);
    chk({tag, ".funct3"}, 32'(funct3), 32'd0);
    chk({tag, ".invertb"}, 32'(invertb), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; wb_rd = '0; wb_data = '0;

    tbl[0]  = '{"add",      32'h002081B3, 5'd0, 32'h0,        5'd3,  32'd5,        32'd3,        6'd0,  3'd0, 1'b0, 1'b0};
    tbl[1]  = '{"sub",      32'h40208233, 5'd0, 32'h0,        5'd4,  32'd5,        32'hFFFFFFFD, 6'd0,  3'd0, 1'b1, 1'b0};
    tbl[2]  = '{"srai",     32'h4040D293, 5'd0, 32'h0,        5'd5,  32'd5,        32'h00000404, 6'd4,  3'd5, 1'b1, 1'b0};
    tbl[3]  = '{"slli31",   32'h01F09293, 5'd0, 32'h0,        5'd5,  32'd5,        32'h0000001F, 6'd31, 3'd1, 1'b0, 1'b0};
    tbl[4]  = '{"sra",      32'h4020D533, 5'd0, 32'h0,        5'd10, 32'd5,        32'd3,        6'd3,  3'd5, 1'b1, 1'b0};
    tbl[5]  = '{"addi_m1",  32'hFFF00593, 5'd0, 32'h0,        5'd11, 32'd0,        32'hFFFFFFFF, 6'd0,  3'd0, 1'b0, 1'b0};
    tbl[6]  = '{"ori_b30",  32'h40016613, 5'd0, 32'h0,        5'd12, 32'd3,        32'h00000400, 6'd0,  3'd6, 1'b0, 1'b0};
    tbl[7]  = '{"wb_byp",   32'h00040493, 5'd8, 32'hDEADBEEF, 5'd9,  32'hDEADBEEF, 32'd0,        6'd0,  3'd0, 1'b0, 1'b0};
    tbl[8]  = '{"wb_arr",   32'h000406B3, 5'd0, 32'h0,        5'd13, 32'hDEADBEEF, 32'd0,        6'd0,  3'd0, 1'b0, 1'b0};
    tbl[9]  = '{"x0_read",  32'h00000793, 5'd0, 32'h00001234, 5'd15, 32'd0,        32'd0,        6'd0,  3'd0, 1'b0, 1'b0};
    tbl[10] = '{"illegal",  32'h0000007F, 5'd0, 32'h0,        5'd0,  32'd0,        32'd0,        6'd0,  3'd0, 1'b0, 1'b1};
    tbl[11] = '{"sll",      32'h00209833, 5'd0, 32'h0,        5'd16, 32'd5,        32'd3,        6'd3,  3'd1, 1'b0, 1'b0};

    // Reset state
    #2;
    chk_bubble("reset");
    chk("reset.illegal", 32'(illegal), 32'd0);
    chk("reset.ready", 32'(instr_ready), 32'd1);
    #10 rst_n = 1'b1;
    step();

    // Preload x1=5, x2=3 through the write-back port
    wb_rd = 5'd1; wb_data = 32'd5;
    step();
    wb_rd = 5'd2; wb_data = 32'd3;
    step();
    wb_rd = '0; wb_data = '0;

    foreach (tbl[i]) begin
      instr = tbl[i].instr; instr_valid = 1'b1;
      wb_rd = tbl[i].wb_rd; wb_data = tbl[i].wb_data;
      #1;
      chk({tbl[i].name, ".ready"}, 32'(instr_ready), 32'd1);
      @(posedge clk);
      #1;
      instr_valid = 1'b0; wb_rd = '0; wb_data = '0;
      chk({tbl[i].name, ".rd"}, 32'(rd), 32'(tbl[i].rd));
      chk({tbl[i].name, ".a"}, a, tbl[i].a);
      chk({tbl[i].name, ".b"}, b, tbl[i].b);
      chk({tbl[i].name, ".shamt"}, 32'(shamt), 32'(tbl[i].shamt));
      chk({tbl[i].name, ".funct3"}, 32'(funct3), 32'(tbl[i].f3));
      chk({tbl[i].name, ".invertb"}, 32'(invertb), 32'(tbl[i].inv));
      chk({tbl[i].name, ".illegal"}, 32'(illegal), 32'(tbl[i].ill));
    end

    // Idle: bubble registered, ready high with no valid
    step();
    chk_bubble("idle");
    chk("idle.ready", 32'(instr_ready), 32'd1);

    // Back-to-back dependent pair: ADDI x6,x0,7 then ADD x7,x6,x6, EX emulated via wb
    instr = 32'h00700313; instr_valid = 1'b1;
    step();
    chk("dep.i1_rd", 32'(rd), 32'd6);
    chk("dep.i1_b", b, 32'd7);
    instr = 32'h006303B3;
    #1;
    chk("dep.stall_ready", 32'(instr_ready), 32'd0);
    step();
    chk_bubble("dep.bubble");
    wb_rd = 5'd6; wb_data = 32'd7;
    #1;
    chk("dep.ready_back", 32'(instr_ready), 32'd1);
    step();
    instr_valid = 1'b0; wb_rd = '0; wb_data = '0;
    chk("dep.i2_rd", 32'(rd), 32'd7);
    chk("dep.i2_a", a, 32'd7);
    chk("dep.i2_b", b, 32'd7);
    step();

    // Distance-2 read of x6 comes from the array
    instr = 32'h00030893; instr_valid = 1'b1;
    #1;
    chk("dist2.ready", 32'(instr_ready), 32'd1);
    step();
    instr_valid = 1'b0;
    chk("dist2.a", a, 32'd7);

    // Reset asserted in the middle of a stall
    step();
    instr = 32'h00700313; instr_valid = 1'b1;
    step();
    instr = 32'h006303B3;
    #1;
    chk("rststall.ready_lo", 32'(instr_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_bubble("rststall");
    chk("rststall.ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // Register file was cleared: ADD x3,x1,x2 now reads zeros
    instr = 32'h002081B3; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("postrst.rd", 32'(rd), 32'd3);
    chk("postrst.a", a, 32'd0);
    chk("postrst.b", b, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_id.md
# riscv_id

Instruction decode stage of the riscv pipeline: accepts 32-bit instruction words via a valid/ready handshake and owns the 32-entry integer register file. It decodes RV32I OP and OP-IMM instructions into the registered operand bundle consumed by riscv_ex: rd, a, b, shamt, funct3, invertb. It takes the EX stage's registered result and rd back as the write-back port. It interlocks against the single instruction in flight in EX.

## Interface
- XLEN, 32: datapath width
- REGA, 5: register address width (32 registers)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction word
- instr_valid  in  1  instr is presented
- instr_ready  out  1  instr accepted at this rising edge when valid&ready (combinational)
- wb_rd  in  REGA  write-back register, driven by EX `rd`
- wb_data  in  XLEN  write-back value, driven by EX `result`
- rd  out  REGA  destination register to EX
- a  out  XLEN  operand A (rs1 value)
- b  out  XLEN  operand B (rs2 value, sign-extended immediate, or negated rs2)
- shamt  out  6  shift amount
- funct3  out  3  ALU operation
- invertb  out  1  set for SUB and SRA/SRAI
- illegal  out  1  one-cycle pulse: the accepted instruction was unsupported

## Operation
- Register file: 32×XLEN, all entries cleared by reset. Written at each rising edge when wb_rd≠0. x0 always reads 0.
- Read bypass: if rsN==wb_rd and wb_rd≠0, the operand is wb_data (write-first). Otherwise it is the array value.
- Supported opcodes (instr[6:0]):
  - OP-IMM 0010011:
    - a=rs1; b=sext(instr[31:20]); funct3=instr[14:12].
    - For SLLI/SRLI/SRAI: shamt={1'b0,instr[24:20]}, and invertb=instr[30] only when funct3=101.
  - OP 0110011:
    - a=rs1; b=rs2; shamt={1'b0,rs2[4:0]}.
    - invertb=instr[30] when funct3 is 000 or 101.
    - SUB (funct3=000, instr[30]=1) drives b=(~rs2)+1, truncated to XLEN, so EX's ADD produces rs1−rs2.
  - In both opcodes rd=instr[11:7].
  - shamt=0 for non-shift funct3.
- Unsupported opcode when accepted: output a bubble and set illegal=1 for one cycle. The instruction is consumed.
- Bubble: rd=0, a=0, b=0, shamt=0, funct3=000, invertb=0, illegal=0.
- Hazard:
  - Condition: instr_valid=1, the output register holds rd≠0, and rd equals a source actually used. OP uses rs1 and rs2; OP-IMM uses rs1; unsupported opcodes use none.
  - Response: instr_ready=0 and a bubble is registered.
  - On the next cycle that rd is wb_rd, the bypass supplies the value, and ready rises.
- instr_ready=1 whenever no hazard exists, including when instr_valid=0.
- No valid instruction (instr_valid=0) or no accept: register a bubble.

## Timing
- Reset (rst_n=0, asynchronous): rd, a, b, shamt, funct3, invertb, illegal = 0. All registers = 0. instr_ready is combinational and evaluates to 1.
- Latency: an instruction accepted at edge k has its outputs valid from edge k until edge k+1. EX registers its result at k+1. The register file write occurs at k+2.
- Back-to-back dependent pair (I2 reads I1.rd):
  - I1 is accepted at k.
  - During k..k+1, ready=0 and a bubble is registered at k+1.
  - I2 is accepted at k+2, with its operand bypassed from wb_data.
  - Penalty: one bubble.
- Dependency at distance ≥2: no stall. The bypass or the array supplies the value.
- Writes to x0 (wb_rd=0) are ignored. rd=0 never causes a stall.
- Simultaneous write-back and read of the same register: the read returns wb_data.
- Reset asserted mid-stall: the outputs clear immediately. After release, ready=1 and the pending instruction must be re-presented by the upstream stage.
- instr must be held stable while instr_valid=1 and instr_ready=0.

## Test plan
- Reset, then the register file is preloaded via wb_rd/wb_data = x1←5 and x2←3. Accept ADD x3,x1,x2 (0x002081B3) → next cycle: rd=3, a=5, b=3, funct3=000, invertb=0.
- SUB x4,x1,x2 (0x40208233) with x1=5, x2=3 → a=5, b=0xFFFFFFFD, invertb=1, funct3=000.
- SRAI x5,x1,4 (0x4040D293) → b=sext(0x404), shamt=4, funct3=101, invertb=1. SLLI x5,x1,31 → shamt=31, invertb=0.
- ADDI x6,x0,7 then ADD x7,x6,x6 presented back-to-back:
  - instr_ready=0 for exactly one cycle, and a bubble (rd=0) is emitted.
  - With EX attached, the second instruction then shows a=b=7.
- Write-back of x8←0xDEADBEEF in the same cycle that ADDI x9,x8,0 is accepted → a=0xDEADBEEF. A write to x0 followed by reading x0 → 0.
- Opcode 0x0000007F accepted → illegal=1 for one cycle with bubble outputs. Asserting rst_n=0 during a stall → all outputs 0 immediately and ready=1.
